// File: rtl/dec_to_fp.sv
// dec_to_fp: iterative decimal fixed-point (integer + millionths) to IEEE-754
// single-precision converter. Generates binary fraction bits by repeated
// doubling of the decimal remainder, normalizes one bit per cycle, then
// rounds to nearest-even. One conversion in flight; start/done handshake.
module dec_to_fp #(
    parameter int FRAC_SCALE = 1000000,
    parameter int GEN_BITS   = 48
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [4:0]  nguyen,
    input  logic [19:0] le,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        err
);

    localparam int          MW     = GEN_BITS + 5;
    localparam logic [20:0] SCALE  = 21'(FRAC_SCALE);
    localparam logic [19:0] LE_MAX = 20'(FRAC_SCALE - 1);
    localparam logic [5:0]  LAST   = 6'(GEN_BITS - 1);

    typedef enum logic [2:0] {IDLE, GEN, NORM, ROUND, DONE} state_t;

    state_t          state, nxt;
    logic [MW-1:0]   m;       // {integer[4:0], binary fraction}
    logic [19:0]     rem;     // decimal remainder, always < FRAC_SCALE
    logic [5:0]      cnt;
    logic [4:0]      k;       // normalization shift count
    logic            sticky;  // remainder nonzero after last generated bit

    logic            bad_in, zero_in;
    logic [20:0]     rem2;
    logic            gbit;
    logic [19:0]     rem_nx;
    logic [22:0]     man;
    logic            g, s, rup;
    logic [23:0]     man_r;
    logic [7:0]      exp_r;
    logic [22:0]     man_f;

    assign bad_in  = (le > LE_MAX);
    assign zero_in = (nguyen == 5'd0) && (le == 20'd0);

    // One restoring step of decimal-to-binary fraction conversion
    always_comb begin
        rem2   = {rem, 1'b0};
        gbit   = (rem2 >= SCALE);
        rem_nx = gbit ? 20'(rem2 - SCALE) : rem2[19:0];
    end

    // Round-to-nearest-even on the normalized mantissa; carry-out bumps exponent
    always_comb begin
        man   = m[MW-2 -: 23];
        g     = m[MW-25];
        s     = (|m[MW-26:0]) | sticky;
        rup   = g & (s | man[0]);
        man_r = {1'b0, man} + {23'd0, rup};
        exp_r = 8'd131 - {3'd0, k} + {7'd0, man_r[23]};
        man_f = man_r[23] ? 23'd0 : man_r[22:0];
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (bad_in || zero_in) ? DONE : GEN;
            GEN:     if (cnt == LAST) nxt = NORM;
            NORM:    if (m[MW-1]) nxt = ROUND;
            ROUND:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == GEN) || (state == NORM) || (state == ROUND);
        done = (state == DONE);
    end

    // Datapath: latch inputs, generate bits, normalize, round
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m      <= '0;
            rem    <= '0;
            cnt    <= '0;
            k      <= '0;
            sticky <= 1'b0;
            out    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (bad_in) begin
                        err <= 1'b1;
                    end else begin
                        err <= 1'b0;
                        if (zero_in) out <= '0;
                        m      <= {nguyen, {GEN_BITS{1'b0}}};
                        rem    <= le;
                        cnt    <= '0;
                        k      <= '0;
                        sticky <= 1'b0;
                    end
                end
                GEN: begin
                    // Shifting bits in at the LSB places the first one at the
                    // fraction MSB after GEN_BITS steps.
                    m[GEN_BITS-1:0] <= {m[GEN_BITS-2:0], gbit};
                    rem             <= rem_nx;
                    cnt             <= cnt + 6'd1;
                    if (cnt == LAST) sticky <= (rem_nx != 20'd0);
                end
                NORM: if (!m[MW-1]) begin
                    m <= m << 1;
                    k <= k + 5'd1;
                end
                ROUND: out <= {1'b0, exp_r, man_f};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_fp.sv
// tb_dec_to_fp: directed scoreboard bench for dec_to_fp.
module tb_dec_to_fp;

    logic        CLK, RST, start;
    logic [4:0]  nguyen;
    logic [19:0] le;
    logic        busy, done, err;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] o;
        logic        e;
        int          lat;
    } exp_t;
    exp_t q[$];

    dec_to_fp dut (
        .CLK(CLK), .RST(RST), .start(start), .nguyen(nguyen), .le(le),
        .busy(busy), .done(done), .out(out), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Push expectation, pulse start, wait (bounded) for done, pop and compare.
    // inj > 0 re-pulses start with other inputs that many cycles in.
    task automatic run(input logic [4:0] n, input logic [19:0] l, input logic [31:0] eo,
                       input logic ee, input int el, input int inj);
        int   cyc;
        int   extra;
        exp_t e;
        q.push_back('{eo, ee, el});
        @(negedge CLK);
        nguyen = n; le = l; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            if (cyc == 2 && el > 1) chk("busy_mid", {31'd0, busy}, 32'd1);
            if (cyc == inj) begin
                start = 1'b1; nguyen = 5'd2; le = 20'd250000;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        start = 1'b0;
        e = q.pop_front();
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("out", out, e.o);
        chk("err", {31'd0, err}, {31'd0, e.e});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge CLK); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("out_hold", out, e.o);
        if (inj > 0) begin
            extra = 0;
            for (int i = 0; i < 80; i++) begin
                @(posedge CLK); #1;
                if (done) extra++;
            end
            chk("single_done", 32'(extra), 32'd0);
            chk("out_after_ignore", out, e.o);
        end
    endtask

    initial begin
        start = 1'b0; nguyen = '0; le = '0;
        RST = 1'b1;
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", out, 32'h0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge CLK); RST = 1'b1;

        run(5'd0,  20'd30000,   32'h3CF5C28F, 1'b0, 61, 0);
        run(5'd1,  20'd500000,  32'h3FC00000, 1'b0, 55, 0);
        run(5'd0,  20'd100000,  32'h3DCCCCCD, 1'b0, 59, 0);
        run(5'd0,  20'd1,       32'h358637BD, 1'b0, 75, 0);
        run(5'd3,  20'd1000000, 32'h358637BD, 1'b1, 1,  0);
        run(5'd0,  20'd0,       32'h00000000, 1'b0, 1,  0);
        run(5'd1,  20'd500000,  32'h3FC00000, 1'b0, 55, 10);

        // Asynchronous reset in the middle of GEN
        @(negedge CLK);
        nguyen = 5'd5; le = 20'd123456; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (20) @(posedge CLK);
        #3;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_out", out, 32'h3FC00000);
        RST = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_out", out, 32'h0);
        chk("arst_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("arst_hold_done", {31'd0, done}, 32'd0);
        @(negedge CLK); RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("no_done_after_abort", {31'd0, done}, 32'd0);

        run(5'd31, 20'd0, 32'h41F80000, 1'b0, 51, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_to_fp.md
Name: dec_to_fp

Overview:
- Iterative converter from a decimal fixed-point pair to an IEEE-754 single-precision word.
- Input is a 5-bit integer part plus a fraction expressed in millionths. Output is a normalized, round-to-nearest-even float.
- It is the inverse path of the float-to-integer/fraction splitter and is used for round-trip checks and for writing results back as floats.
- Multi-cycle FSM with a start/done handshake; one conversion at a time.

Parameters:
- FRAC_SCALE, 1000000: decimal weight of le (le/FRAC_SCALE = fractional value).
- GEN_BITS, 48: number of binary fraction bits generated before normalization.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- nguyen  input  5  unsigned integer part, 0..31.
- le  input  20  fraction in millionths, legal range 0..999999.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; out and err are valid from this cycle onward.
- out  output  32  IEEE-754 result {sign=0, exp[7:0], man[22:0]}; holds until the next done.
- err  output  1  set with done when le > 999999; cleared on the next accepted start.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; busy=0, done=0, out=32'h0, err=0; all internal registers cleared. Reset mid-conversion aborts it with no done.
- IDLE, start=1:
  - Latch nguyen and le.
  - If le > 999999: go to DONE with err=1; out is unchanged.
  - Else if nguyen=0 and le=0: go to DONE with out=32'h00000000.
  - Else: go to GEN with rem=le, M[52:48]=nguyen, M[47:0]=0, cnt=0.
- GEN (exactly GEN_BITS cycles): each cycle rem2=2*rem (21-bit).
  - If rem2 >= FRAC_SCALE: bit=1, rem=rem2-FRAC_SCALE.
  - Else: bit=0, rem=rem2.
  - Bit is written to M[47-cnt]; cnt increments. After cnt=47, go to NORM.
  - stickyR = (rem != 0) after the last GEN cycle.
- NORM: one cycle per evaluation.
  - If M[52]=1: go to ROUND.
  - Else: M <<= 1 and k++ (k starts at 0).
  - Nonzero input guarantees k <= 24.
- ROUND (1 cycle):
  - exp = 131 - k; man = M[51:29]; G = M[28]; S = |M[27:0] | stickyR.
  - Round up when G & (S | man[0]).
  - Mantissa carry-out sets man=0 and exp+1.
  - Register out = {1'b0, exp, man}. Go to DONE.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in the same cycle is ignored.
- Latency from the start-sampling edge:
  - Nonzero input: done rises k+51 cycles later.
  - Zero or error input: done rises 1 cycle later.
- start while busy or in DONE is ignored; the latched inputs are not disturbed.
- All arithmetic is unsigned. The sign bit is always 0. No subnormal, Inf or NaN can be produced: range is 1e-6 .. 31.999999.

Test Plan:
- nguyen=0, le=30000, start pulse → k=10; done 61 cycles after start; out=32'h3CF5C28F; err=0.
- nguyen=1, le=500000 → done after 55 cycles; out=32'h3FC00000. Then nguyen=0, le=100000 → out=32'h3DCCCCCD (round-up path).
- nguyen=0, le=1 → out=32'h358637BD (deepest normalization, k=24). Then nguyen=0, le=0 → done after 1 cycle, out=32'h00000000.
- nguyen=3, le=1000000 → done after 1 cycle with err=1; out keeps its previous value. A following legal start clears err.
- Pulse start again 10 cycles into a conversion with different inputs → ignored; the first result is unchanged and exactly one done pulse occurs.
- Assert RST low during GEN → busy=0, done=0, out=0 immediately (asynchronous). Release, start nguyen=31, le=0 → out=32'h41F80000.
